// File: rtl/memory_unit.sv
// Word-addressed memory with a registered instruction port and a data port fronted
// by a FIFO store buffer that drains into the array whenever the data side is not loading.
module memory_unit #(
  parameter int DEPTH_WORDS = 1024,
  parameter int SB_DEPTH    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] memory_address_bus1,
  output logic [31:0] memory_data_bus1,
  input  logic [31:0] memory_address_bus2,
  inout  wire  [31:0] memory_data_bus2,
  input  logic        memory_write_enable2,
  input  logic        memory_read_enable2,
  output logic        mem_out_busy_w,
  output logic        mem_out_overflow_l
);

  // state  | meaning
  // IDLE   | store buffer empty, nothing to drain
  // DRAIN  | store buffer holds entries, head drains on non-load cycles
  typedef enum logic {S_IDLE, S_DRAIN} state_t;

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int PW = (SB_DEPTH > 1) ? $clog2(SB_DEPTH) : 1;
  localparam int CW = $clog2(SB_DEPTH + 1);

  logic [31:0]   r_mem     [DEPTH_WORDS];
  logic [AW-1:0] r_sb_idx  [SB_DEPTH];
  logic [31:0]   r_sb_data [SB_DEPTH];

  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;
  state_t        r_state;
  logic          r_ovf;
  logic [31:0]   r_data1;
  logic [31:0]   r_load;

  logic [AW-1:0] w_idx1;
  logic [AW-1:0] w_idx2;
  logic          w_full;
  logic          w_drain;
  logic          w_push;
  logic          w_drop;
  logic [31:0]   w_fwd_data;
  logic          w_unused;

  assign w_idx1   = memory_address_bus1[AW+1:2];
  assign w_idx2   = memory_address_bus2[AW+1:2];
  assign w_unused = ^{memory_address_bus1[31:AW+2], memory_address_bus1[1:0],
                      memory_address_bus2[31:AW+2], memory_address_bus2[1:0]};

  assign w_full  = (r_count == CW'(SB_DEPTH));
  assign w_drain = (r_state == S_DRAIN) && !memory_read_enable2;
  // A full buffer still accepts a store when the head drains on the same edge.
  assign w_push  = memory_write_enable2 && (!w_full || w_drain);
  assign w_drop  = memory_write_enable2 && w_full && !w_drain;

  // Walk entries oldest to youngest so the last match wins.
  always_comb begin
    w_fwd_data = r_mem[w_idx2];
    for (int i = 0; i < SB_DEPTH; i++) begin
      if ((CW'(i) < r_count) && (r_sb_idx[r_head + PW'(i)] == w_idx2)) begin
        w_fwd_data = r_sb_data[r_head + PW'(i)];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_state <= S_IDLE;
      r_ovf   <= 1'b0;
      r_data1 <= '0;
      r_load  <= '0;
    end else begin
      r_data1 <= r_mem[w_idx1];
      if (memory_read_enable2) r_load <= w_fwd_data;
      if (w_drain) r_head <= r_head + PW'(1);
      if (w_push)  r_tail <= r_tail + PW'(1);
      if (w_drop)  r_ovf  <= 1'b1;
      case ({w_push, w_drain})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      case (r_state)
        S_IDLE:  if (w_push) r_state <= S_DRAIN;
        S_DRAIN: if (w_drain && !w_push && (r_count == CW'(1))) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Storage is never reset; only the pointers above are.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (w_push) begin
        r_sb_idx[r_tail]  <= w_idx2;
        r_sb_data[r_tail] <= memory_data_bus2;
      end
      if (w_drain) r_mem[r_sb_idx[r_head]] <= r_sb_data[r_head];
    end
  end

  assign memory_data_bus1   = r_data1;
  assign memory_data_bus2   = memory_write_enable2 ? 32'bz : r_load;
  assign mem_out_busy_w     = w_full;
  assign mem_out_overflow_l = r_ovf;

endmodule

// File: tb/tb_memory_unit.sv
// Bench for memory_unit: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_memory_unit;
  localparam int DW = 1024;
  localparam int SB = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] a1, a2, wdata;
  logic        we, re;
  wire  [31:0] bus2;
  wire  [31:0] d1;
  wire         busy, ovf;

  assign bus2 = we ? wdata : 32'bz;

  memory_unit #(.DEPTH_WORDS(DW), .SB_DEPTH(SB)) dut (
    .clk(clk), .reset(reset),
    .memory_address_bus1(a1), .memory_data_bus1(d1),
    .memory_address_bus2(a2), .memory_data_bus2(bus2),
    .memory_write_enable2(we), .memory_read_enable2(re),
    .mem_out_busy_w(busy), .mem_out_overflow_l(ovf)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: array, store-buffer queue, output registers.
  typedef struct { int idx; logic [31:0] data; } ent_t;
  logic [31:0] m_mem   [DW];
  bit          m_known [DW];
  ent_t        m_q[$];
  logic [31:0] m_d1, m_load;
  bit          m_d1_ok, m_ld_ok, m_ovf;
  int          mi1, mi2;
  bit          m_full, m_drain;
  ent_t        m_e;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_q.delete();
      m_d1 = 0; m_load = 0; m_ovf = 0; m_d1_ok = 1; m_ld_ok = 1;
    end else begin
      mi1 = int'((a1 >> 2) % DW);
      mi2 = int'((a2 >> 2) % DW);
      m_full  = (m_q.size() == SB);
      m_drain = !re && (m_q.size() > 0);
      if (re) begin
        m_load = m_mem[mi2]; m_ld_ok = m_known[mi2];
        foreach (m_q[k]) if (m_q[k].idx == mi2) begin m_load = m_q[k].data; m_ld_ok = 1; end
      end
      m_d1 = m_mem[mi1]; m_d1_ok = m_known[mi1];
      if (m_drain) begin
        m_e = m_q.pop_front();
        m_mem[m_e.idx] = m_e.data; m_known[m_e.idx] = 1;
      end
      if (we) begin
        if (!m_full || m_drain) begin
          m_e.idx = mi2; m_e.data = wdata; m_q.push_back(m_e);
        end else m_ovf = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      chk("busy", {31'd0, busy}, {31'd0, m_q.size() == SB});
      chk("overflow", {31'd0, ovf}, {31'd0, m_ovf});
      chk("count", 32'(dut.r_count), 32'(m_q.size()));
      if (m_d1_ok) chk("data_bus1", d1, m_d1);
      if (!we && m_ld_ok) chk("data_bus2", bus2, m_load);
    end
  end

  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic store(input logic [31:0] addr, input logic [31:0] data, input logic rd);
    we = 1; re = rd; a2 = addr; wdata = data;
    tick();
    we = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1; we = 0; re = 0; a1 = 0; a2 = 0; wdata = 0;
    repeat (2) @(negedge clk);
    chk("rst_data1", d1, 32'h0);
    chk("rst_bus2", bus2, 32'h0);
    chk("rst_busy", {31'd0, busy}, 32'h0);
    chk("rst_ovf", {31'd0, ovf}, 32'h0);
    chk("rst_count", 32'(dut.r_count), 32'h0);
    #1 reset = 0;
    tick();

    // Fill the whole array through the store buffer.
    for (int i = 0; i < DW; i++) store(32'(i * 4), 32'hC0DE0000 | 32'(i), 1'b0);
    re = 0; repeat (3) tick();
    chk("init_count", 32'(dut.r_count), 32'h0);

    // Instruction-port read of a preloaded word.
    store(32'h4, 32'hDEADBEEF, 1'b0);
    re = 0; tick();
    a1 = 32'h4; tick();
    chk("ifetch_deadbeef", d1, 32'hDEADBEEF);

    // Two stores to one word, load forwards the younger.
    store(32'h40, 32'h11, 1'b1);
    store(32'h40, 32'h22, 1'b1);
    re = 1; a2 = 32'h40; tick();
    chk("fwd_youngest", bus2, 32'h22);
    chk("fwd_count", 32'(dut.r_count), 32'h2);
    chk("model_fwd", m_load, 32'h22);
    re = 0; repeat (2) tick();
    a1 = 32'h40; tick();
    chk("drained_0x40", d1, 32'h22);

    // Load and store together: load sees pre-push state, result held afterwards.
    we = 1; re = 1; a2 = 32'h40; wdata = 32'h33; tick();
    we = 0; re = 0; #1;
    chk("ld_st_same_cycle", bus2, 32'h22);
    tick();
    a1 = 32'h40; tick();
    chk("ld_st_pushed", d1, 32'h33);

    // Fill, overflow, then drain in order.
    for (int k = 0; k < 4; k++) store(32'h100 + 32'(4 * k), 32'hA1A10000 + 32'(k), 1'b1);
    chk("full_busy", {31'd0, busy}, 32'h1);
    store(32'h110, 32'hBAD0BAD0, 1'b1);
    chk("drop_ovf", {31'd0, ovf}, 32'h1);
    chk("drop_count", 32'(dut.r_count), 32'h4);
    re = 0; repeat (4) tick();
    chk("drain_count", 32'(dut.r_count), 32'h0);
    for (int k = 0; k < 4; k++) begin
      a1 = 32'h100 + 32'(4 * k); tick();
      chk("drain_order", d1, 32'hA1A10000 + 32'(k));
    end
    a1 = 32'h110; tick();
    chk("dropped_not_written", d1, 32'hC0DE0044);

    reset = 1; tick(); reset = 0; tick();
    chk("ovf_cleared", {31'd0, ovf}, 32'h0);

    // Store accepted while full because the head drains on the same edge.
    re = 1;
    for (int k = 0; k < 4; k++) store(32'h180 + 32'(4 * k), 32'hB0B00000 + 32'(k), 1'b1);
    store(32'h190, 32'hB4B4B4B4, 1'b0);
    chk("push_drain_busy", {31'd0, busy}, 32'h1);
    chk("push_drain_ovf", {31'd0, ovf}, 32'h0);
    chk("push_drain_count", 32'(dut.r_count), 32'h4);
    re = 0; repeat (4) tick();
    a1 = 32'h190; tick();
    chk("push_drain_data", d1, 32'hB4B4B4B4);

    // Asynchronous reset discards pending stores; requests during reset ignored.
    for (int k = 0; k < 3; k++) store(32'h200 + 32'(4 * k), 32'hE0E00000 + 32'(k), 1'b1);
    chk("pre_rst_count", 32'(dut.r_count), 32'h3);
    reset = 1; #1;
    chk("arst_data1", d1, 32'h0);
    chk("arst_bus2", bus2, 32'h0);
    chk("arst_busy", {31'd0, busy}, 32'h0);
    chk("arst_count", 32'(dut.r_count), 32'h0);
    we = 1; re = 0; a2 = 32'h300; wdata = 32'hFFFFFFFF; tick();
    we = 0; reset = 0;
    re = 1; a2 = 32'h300; tick();
    chk("ignored_in_reset", bus2, 32'hC0DE00C0);
    for (int k = 0; k < 3; k++) begin
      a2 = 32'h200 + 32'(4 * k); tick();
      chk("old_array_data", bus2, 32'hC0DE0080 + 32'(k));
    end

    // Address wrap and low-bit masking.
    a1 = 32'h1003; tick();
    chk("wrap_port1", d1, 32'hC0DE0000);
    re = 1; a2 = 32'h1003; tick();
    chk("wrap_port2", bus2, 32'hC0DE0000);
    store(32'h1004, 32'h5A5A5A5A, 1'b0);
    re = 0; tick();
    a1 = 32'h4; tick();
    chk("wrap_store", d1, 32'h5A5A5A5A);

    // Mixed traffic over a few aliased words, checked by the model.
    for (int c = 0; c < 400; c++) begin
      we    = 1'($urandom_range(0, 1));
      re    = 1'($urandom_range(0, 2) == 0);
      a1    = (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
      a2    = (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3))
              | (32'($urandom_range(0, 1)) << 12);
      wdata = $urandom;
      tick();
    end
    we = 0; re = 0; repeat (6) tick();
    chk("final_count", 32'(dut.r_count), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule

// File: doc/memory_unit.md
MEMORY_UNIT -- requirements
Module: memory_unit

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, meaning backing array size in 32-bit words (power of two).
REQ-002 SHALL have parameter SB_DEPTH, default 4, meaning store-buffer entries (power of two, 2..8).
REQ-003 SHALL use one clock, clk; reset is asynchronous and active-high, named reset.
REQ-004 SHALL have ports:
- clk, input, 1, rising-edge clock.
- reset, input, 1, async active-high reset.
- memory_address_bus1, input, 32, instruction byte address.
- memory_data_bus1, output, 32, instruction word.
- memory_address_bus2, input, 32, data byte address.
- memory_data_bus2, inout, 32, data bus.
- memory_write_enable2, input, 1, store request this cycle.
- memory_read_enable2, input, 1, load request this cycle.
- mem_out_busy_w, output, 1, store buffer full.
- mem_out_overflow_l, output, 1, sticky dropped-store flag.

Function
REQ-005 SHALL index the array with address bits [log2(DEPTH_WORDS)+1:2], ignore bits [1:0], and wrap out-of-range upper bits modulo DEPTH_WORDS.
REQ-006 SHALL register the port-1 read: memory_data_bus1 equals the word at the address sampled on the previous edge (1-cycle latency), every cycle, with no enable.
REQ-007 SHALL return port-1 data from the array only, with no store-buffer forwarding; instruction-side coherence is software's responsibility.
REQ-008 SHALL, on memory_write_enable2=1 and not full, push {word index, memory_data_bus2} into a FIFO store buffer at the tail.
REQ-009 SHALL register port-2 load data with 1-cycle latency; the result is held until the next load.
REQ-010 SHALL forward on a load: if any buffer entry matches the word index, return the youngest matching entry; otherwise return the array word.
REQ-011 SHALL drive memory_data_bus2 with the registered load data whenever memory_write_enable2=0, and high-Z whenever memory_write_enable2=1.
REQ-012 SHALL drain the head entry into the array in any cycle with memory_read_enable2=0 and count>0; one entry per cycle.
REQ-013 SHALL make a load take priority over drain in the same cycle; the drain waits.
REQ-014 SHALL, when a push and a drain coincide, perform both, leaving count unchanged.
REQ-015 SHALL, when a load and a store are requested in the same cycle, complete the load from the pre-push state and perform the push.
REQ-016 SHALL assert mem_out_busy_w combinationally when count==SB_DEPTH.
REQ-017 SHALL, on a store while full with no same-cycle drain, drop the store, leave the buffer unchanged, and set mem_out_overflow_l until reset.
REQ-018 SHALL wrap head/tail pointers modulo SB_DEPTH; count SHALL range 0..SB_DEPTH with no wrap.
REQ-019 SHALL use a two-state drain FSM: IDLE (count==0) and DRAIN (count>0); IDLE->DRAIN on push, DRAIN->IDLE when the last entry drains with no push.

Reset
REQ-020 SHALL, on reset: count, head and tail =0; FSM=IDLE; memory_data_bus1=0; load data register=0; mem_out_busy_w=0; mem_out_overflow_l=0.
REQ-021 SHALL discard pending buffer entries on a mid-operation reset; array contents SHALL NOT be reset.
REQ-022 SHALL ignore all requests while reset is high.

Verification
REQ-023 SHALL cover: preload word 0x4=0xDEADBEEF, address_bus1=0x4 -> data_bus1=0xDEADBEEF on the next edge.
REQ-024 SHALL cover: store 0x11 to 0x40, then store 0x22 to 0x40, then load 0x40 with read_enable held -> 0x22 via forwarding, count==2.
REQ-025 SHALL cover: 4 stores with read_enable=1 -> busy=1; a 5th store -> dropped, overflow=1; read_enable=0 for 4 cycles -> count=0, array holds the 4 values in order.
REQ-026 SHALL cover: store and drain in the same cycle at count=4 -> accepted, busy stays 1, overflow stays 0.
REQ-027 SHALL cover: reset asserted with count=3 -> count=0, busy=0, outputs 0 immediately (asynchronously); a load of those addresses -> old array data.
REQ-028 SHALL cover: address 0x1003 with DEPTH_WORDS=1024 -> accesses word 0 (wrap, low bits ignored).
